minmax_tree: RTL and testbench
==============================

# minmax_tree

Parametrised, pipelined min/max reduction over N lanes of W-bit data, with a valid-qualified stream interface and an optional running (accumulating) mode. Generalises the fixed 4-input, 2-bit min/max unit:
- configurable lane count, width and signedness;
- fully pipelined, one new sample set per cycle;
- optional winning-lane index.

It sits between the input capture registers and the LED/display or downstream statistics logic.

## Interface
Parameters:
- N, 4, lane count; power of two, ≥2
- W, 2, lane data width, ≥1
- SIGNED, 0, 1 = lanes compared as two's complement, 0 = unsigned

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  in_data holds a sample set this cycle
- in_data  in  N*W  lane i at bits [i*W +: W]
- acc_en  in  1  1 = running min/max across sample sets, 0 = per-set result
- acc_clr  in  1  clear running accumulator (synchronous)
- out_valid  out  1  one-cycle pulse per result
- out_min  out  W  minimum
- out_max  out  W  maximum
- out_min_idx  out  $clog2(N)  lane of minimum (only with MINMAX_INDEX_EN)
- out_max_idx  out  $clog2(N)  lane of maximum (only with MINMAX_INDEX_EN)

## Operation
- Binary tree of S = $clog2(N) registered compare levels. Each node outputs min, max and the lane index of each.
- A valid bit travels alongside each level. No backpressure: in_valid may be high every cycle.
- Tie-break: on equal values the lower lane index wins, for both min and max.
- Output stage (one register) takes the tree-root result when the root valid is set:
  - acc_en=0: out_min/out_max = root values.
  - acc_en=1, accumulator empty: load the root values; accumulator becomes non-empty.
  - acc_en=1, accumulator non-empty: out_min = min(out_min, root_min), out_max = max(out_max, root_max).
  - On ties during accumulation, the held value and index are kept (earliest set wins).
  - out_valid=1 for that cycle in all of the above cases.
- acc_clr marks the accumulator empty. If a root result arrives in the same cycle, the clear applies first, then the result loads fresh.
- acc_en is sampled at the output stage (root-valid cycle), not at input.
- Between results, out_min/out_max/idx hold their last value; out_valid=0.
- Arithmetic: pure compare, no width growth. SIGNED selects $signed compare at every node and in the accumulator.

## Timing
- Latency: in_valid at cycle t → out_valid at t+S+1. N=4 → 3 cycles; N=8 → 4 cycles.
- Throughput: one set per cycle.
- Reset (rst=0 at posedge):
  - every pipeline valid and out_valid → 0;
  - out_min, out_max, indices → 0;
  - accumulator → empty.
- Reset mid-stream discards all in-flight sets; no result for them ever appears.
- First in_valid sampled in the cycle after rst returns high is processed normally.

## Configuration
- MINMAX_INDEX_EN defined:
  - index fields are carried through the tree and accumulator;
  - out_min_idx/out_max_idx ports exist; reset value 0.
- Not defined: index logic and ports are absent; value behaviour is identical.

## Structure
- Package minmax_pkg:
  - function lt(a, b, signed_mode);
  - typedef of node result struct {min, max, min_idx, max_idx} parametrised via localparams;
  - IDXW = $clog2(N) helper.
- Sub-module minmax_node: one registered 2-input node. Takes two node results plus valid and outputs a merged result plus valid, with lower-index tie-break.
- Top level: generate tree of minmax_node, then accumulator/output stage.

## Test plan
- N=4, W=2, unsigned; lanes {3,1,2,0} (lane0=3) with one valid → 3 cycles later out_valid pulse, min=0/idx 3, max=3/idx 0.
- Back-to-back sets {1,1,1,1} then {2,3,3,0} → consecutive pulses:
  - first: min=1 idx0, max=1 idx0;
  - second: min=0 idx3, max=3 idx1.
- acc_en=1; sets {2,2,2,2}, {1,3,2,2}, {2,2,2,2}:
  - outputs 2/2, then 1/3, then 1/3 (indices unchanged on ties).
  - Then acc_clr coincident with a root result {0,0,0,0} → 0/0.
- N=8, W=4, SIGNED=1; lanes {-8,7,0,-1,3,-8,7,2} → latency 4, min=-8 idx0, max=7 idx1.
- rst asserted one cycle after two in_valid sets → no out_valid for either; all outputs 0; next set after release yields correct result at normal latency.
- Build without MINMAX_INDEX_EN, rerun scenario 1 → same min/max values; no index ports.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared helpers for the min/max reduction tree: widest supported lane width,
// index-width helper and the common compare used by every node and the
// output accumulator.
package minmax_pkg;

    // Lanes are widened to this many bits before comparing so one compare
    // function serves every lane width up to this limit.
    localparam int MAXW = 64;

    // Width of a lane index for an n-lane tree (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Strict less-than on pre-widened operands; signed_mode selects two's complement.
    function automatic logic lt(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input logic            signed_mode
    );
        if (signed_mode) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

endpackage

// File: rtl/minmax_node.sv
// One registered 2-input node of the min/max tree. Input a always covers the
// lower lane indices, so keeping a on a tie gives the lower-index-wins rule.
// Index fields exist only when MINMAX_INDEX_EN is defined.
module minmax_node import minmax_pkg::*; #(
    parameter int W      = 2,
`ifdef MINMAX_INDEX_EN
    parameter int IDXW   = 2,
`endif
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic         b_valid,
    input  logic [W-1:0] a_min,
    input  logic [W-1:0] a_max,
    input  logic [W-1:0] b_min,
    input  logic [W-1:0] b_max,
    output logic         y_valid,
    output logic [W-1:0] y_min,
    output logic [W-1:0] y_max
`ifdef MINMAX_INDEX_EN
    ,
    input  logic [IDXW-1:0] a_min_idx,
    input  logic [IDXW-1:0] a_max_idx,
    input  logic [IDXW-1:0] b_min_idx,
    input  logic [IDXW-1:0] b_max_idx,
    output logic [IDXW-1:0] y_min_idx,
    output logic [IDXW-1:0] y_max_idx
`endif
);

    // Widen a lane to the shared compare width, honouring signedness.
    function automatic logic [MAXW-1:0] ext(input logic [W-1:0] x);
        if (SIGNED) begin
            return MAXW'($signed(x));
        end
        return MAXW'(x);
    endfunction

    logic take_b_min;
    logic take_b_max;

    // Select the upper-lane child only when it is strictly better.
    always_comb begin
        take_b_min = lt(ext(b_min), ext(a_min), SIGNED);
        take_b_max = lt(ext(a_max), ext(b_max), SIGNED);
    end

    // Valid bit travels with the data; cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst) begin
            y_valid <= 1'b0;
        end else begin
            y_valid <= a_valid & b_valid;
        end
    end

    // Merged min/max captured only for valid sets.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; they are only observed
        // when the accompanying valid bit (which is reset) is set.
        if (a_valid & b_valid) begin
            y_min <= take_b_min ? b_min : a_min;
            y_max <= take_b_max ? b_max : a_max;
`ifdef MINMAX_INDEX_EN
            y_min_idx <= take_b_min ? b_min_idx : a_min_idx;
            y_max_idx <= take_b_max ? b_max_idx : a_max_idx;
`endif
        end
    end

endmodule

// File: rtl/minmax_tree.sv
// Pipelined min/max reduction over N lanes with optional running accumulation.
// Tree nodes are stored heap-style: node k has children 2k (lower lanes) and
// 2k+1; entries N..2N-1 are the unregistered lane leaves, entry 1 the root.
// Define MINMAX_INDEX_EN to carry winning-lane indices and expose index ports.
module minmax_tree import minmax_pkg::*; #(
    parameter int N      = 4,
    parameter int W      = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic           acc_en,
    input  logic           acc_clr,
    output logic           out_valid,
    output logic [W-1:0]   out_min,
    output logic [W-1:0]   out_max
`ifdef MINMAX_INDEX_EN
    ,
    output logic [$clog2(N)-1:0] out_min_idx,
    output logic [$clog2(N)-1:0] out_max_idx
`endif
);

`ifdef MINMAX_INDEX_EN
    localparam int IDXW = idx_w(N);
`endif

    // Widen a lane to the shared compare width, honouring signedness.
    function automatic logic [MAXW-1:0] ext(input logic [W-1:0] x);
        if (SIGNED) begin
            return MAXW'($signed(x));
        end
        return MAXW'(x);
    endfunction

    logic         t_valid [1:2*N-1];
    logic [W-1:0] t_min   [1:2*N-1];
    logic [W-1:0] t_max   [1:2*N-1];
`ifdef MINMAX_INDEX_EN
    logic [IDXW-1:0] t_min_idx [1:2*N-1];
    logic [IDXW-1:0] t_max_idx [1:2*N-1];
`endif

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign t_valid[N+i] = in_valid;
        assign t_min[N+i]   = in_data[i*W +: W];
        assign t_max[N+i]   = in_data[i*W +: W];
`ifdef MINMAX_INDEX_EN
        assign t_min_idx[N+i] = IDXW'(i);
        assign t_max_idx[N+i] = IDXW'(i);
`endif
    end

    for (genvar k = 1; k < N; k++) begin : g_node
        minmax_node #(
            .W      (W),
`ifdef MINMAX_INDEX_EN
            .IDXW   (IDXW),
`endif
            .SIGNED (SIGNED)
        ) u_node (
            .clk     (clk),
            .rst     (rst),
            .a_valid (t_valid[2*k]),
            .b_valid (t_valid[2*k+1]),
            .a_min   (t_min[2*k]),
            .a_max   (t_max[2*k]),
            .b_min   (t_min[2*k+1]),
            .b_max   (t_max[2*k+1]),
            .y_valid (t_valid[k]),
            .y_min   (t_min[k]),
            .y_max   (t_max[k])
`ifdef MINMAX_INDEX_EN
            ,
            .a_min_idx (t_min_idx[2*k]),
            .a_max_idx (t_max_idx[2*k]),
            .b_min_idx (t_min_idx[2*k+1]),
            .b_max_idx (t_max_idx[2*k+1]),
            .y_min_idx (t_min_idx[k]),
            .y_max_idx (t_max_idx[k])
`endif
        );
    end

    logic         acc_full;
    logic         nxt_full;
    logic [W-1:0] nxt_min;
    logic [W-1:0] nxt_max;
`ifdef MINMAX_INDEX_EN
    logic [IDXW-1:0] nxt_min_idx;
    logic [IDXW-1:0] nxt_max_idx;
`endif

    // Output/accumulator next state: clear first, then load or merge the root.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch
        // is inferred on paths that do not assign it.
        nxt_min  = out_min;
        nxt_max  = out_max;
`ifdef MINMAX_INDEX_EN
        nxt_min_idx = out_min_idx;
        nxt_max_idx = out_max_idx;
`endif
        nxt_full = acc_full & ~acc_clr;
        if (t_valid[1]) begin
            if (acc_en && nxt_full) begin
                // Strict compares keep the held (earliest) value on ties.
                if (lt(ext(t_min[1]), ext(out_min), SIGNED)) begin
                    nxt_min = t_min[1];
`ifdef MINMAX_INDEX_EN
                    nxt_min_idx = t_min_idx[1];
`endif
                end
                if (lt(ext(out_max), ext(t_max[1]), SIGNED)) begin
                    nxt_max = t_max[1];
`ifdef MINMAX_INDEX_EN
                    nxt_max_idx = t_max_idx[1];
`endif
                end
            end else begin
                nxt_min = t_min[1];
                nxt_max = t_max[1];
`ifdef MINMAX_INDEX_EN
                nxt_min_idx = t_min_idx[1];
                nxt_max_idx = t_max_idx[1];
`endif
            end
            // A per-set result leaves the accumulator empty; a running one fills it.
            nxt_full = acc_en;
        end
    end

    // Output register; values hold between results, valid pulses per result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_min   <= '0;
            out_max   <= '0;
            acc_full  <= 1'b0;
`ifdef MINMAX_INDEX_EN
            out_min_idx <= '0;
            out_max_idx <= '0;
`endif
        end else begin
            out_valid <= t_valid[1];
            out_min   <= nxt_min;
            out_max   <= nxt_max;
            acc_full  <= nxt_full;
`ifdef MINMAX_INDEX_EN
            out_min_idx <= nxt_min_idx;
            out_max_idx <= nxt_max_idx;
`endif
        end
    end

endmodule

// File: tb/tb_minmax_tree.sv
// Bench for minmax_tree: instance A (N=4, W=2, unsigned) and instance B
// (N=8, W=4, signed). A lane-level reference model predicts every output
// each cycle; directed vectors also carry hand-computed expectations.
// Index checks are compiled only when MINMAX_INDEX_EN is defined.
module tb_minmax_tree;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       a_valid, a_en, a_clr;
    logic [7:0] a_data;
    logic       a_ov;
    logic [1:0] a_min, a_max;
    // Instance B signals
    logic        b_valid, b_en, b_clr;
    logic [31:0] b_data;
    logic        b_ov;
    logic [3:0]  b_min, b_max;
`ifdef MINMAX_INDEX_EN
    logic [1:0] a_min_idx, a_max_idx;
    logic [2:0] b_min_idx, b_max_idx;
`endif

    minmax_tree #(.N(4), .W(2), .SIGNED(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data),
        .acc_en(a_en), .acc_clr(a_clr), .out_valid(a_ov),
        .out_min(a_min), .out_max(a_max)
`ifdef MINMAX_INDEX_EN
        , .out_min_idx(a_min_idx), .out_max_idx(a_max_idx)
`endif
    );

    minmax_tree #(.N(8), .W(4), .SIGNED(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data),
        .acc_en(b_en), .acc_clr(b_clr), .out_valid(b_ov),
        .out_min(b_min), .out_max(b_max)
`ifdef MINMAX_INDEX_EN
        , .out_min_idx(b_min_idx), .out_max_idx(b_max_idx)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit full;
        int mn;
        int mx;
        int mni;
        int mxi;
    } mstate_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    mstate_t sa, sb;
    pend_t   qa[$];
    pend_t   qb[$];
    int      edge_n = 0;
    bit      live = 1'b0;

    function automatic int lane_val(input logic [31:0] d, input int i, input int w, input bit sgn);
        int u = 0;
        for (int b = 0; b < w; b++) begin
            if (d[i*w+b]) u += (1 << b);
        end
        if (sgn && u >= (1 << (w-1))) u -= (1 << w);
        return u;
    endfunction

    // Output after one clock: clear first, then per-set or running result.
    function automatic mstate_t model_out(input mstate_t s, input bit have, input logic [31:0] d,
                                         input int n, input int w, input bit sgn,
                                         input bit en, input bit clr);
        mstate_t r;
        int smn, smx, imn, imx, x;
        r = s;
        r.v = 1'b0;
        if (clr) r.full = 1'b0;
        if (have) begin
            smn = lane_val(d, 0, w, sgn);
            smx = smn;
            imn = 0;
            imx = 0;
            for (int i = 1; i < n; i++) begin
                x = lane_val(d, i, w, sgn);
                if (x < smn) begin smn = x; imn = i; end
                if (x > smx) begin smx = x; imx = i; end
            end
            r.v = 1'b1;
            if (en && r.full) begin
                if (smn < r.mn) begin r.mn = smn; r.mni = imn; end
                if (smx > r.mx) begin r.mx = smx; r.mxi = imx; end
            end else begin
                r.mn = smn; r.mni = imn;
                r.mx = smx; r.mxi = imx;
            end
            r.full = en;
        end
        return r;
    endfunction

    // Model advances on the same edge the DUT registers sample.
    always @(posedge clk) begin
        pend_t p;
        bit    ha, hb;
        p = '{default: 0};
        if (!rst) begin
            qa.delete();
            qb.delete();
            sa = '{default: 0};
            sb = '{default: 0};
            live = 1'b1;
        end else begin
            ha = (qa.size() > 0) && (qa[0].due == edge_n);
            if (ha) p = qa.pop_front();
            sa = model_out(sa, ha, p.data, 4, 2, 1'b0, a_en, a_clr);
            hb = (qb.size() > 0) && (qb[0].due == edge_n);
            if (hb) p = qb.pop_front();
            sb = model_out(sb, hb, p.data, 8, 4, 1'b1, b_en, b_clr);
            if (a_valid) qa.push_back('{due: edge_n + 2, data: {24'd0, a_data}});
            if (b_valid) qb.push_back('{due: edge_n + 3, data: b_data});
        end
        edge_n++;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            check("a_valid", int'(a_ov), int'(sa.v));
            check("a_min", int'(a_min), sa.mn & 3);
            check("a_max", int'(a_max), sa.mx & 3);
            check("b_valid", int'(b_ov), int'(sb.v));
            check("b_min", int'(b_min), sb.mn & 15);
            check("b_max", int'(b_max), sb.mx & 15);
`ifdef MINMAX_INDEX_EN
            check("a_min_idx", int'(a_min_idx), sa.mni);
            check("a_max_idx", int'(a_max_idx), sa.mxi);
            check("b_min_idx", int'(b_min_idx), sb.mni);
            check("b_max_idx", int'(b_max_idx), sb.mxi);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] pk4(input int l0, input int l1, input int l2, input int l3);
        return {l3[1:0], l2[1:0], l1[1:0], l0[1:0]};
    endfunction

    function automatic logic [31:0] pk8(input int l0, input int l1, input int l2, input int l3,
                                        input int l4, input int l5, input int l6, input int l7);
        return {l7[3:0], l6[3:0], l5[3:0], l4[3:0], l3[3:0], l2[3:0], l1[3:0], l0[3:0]};
    endfunction

    task automatic drive_a(input bit v, input logic [7:0] d, input bit en, input bit clr);
        @(negedge clk);
        a_valid = v; a_data = d; a_en = en; a_clr = clr;
        b_valid = 1'b0; b_data = '0; b_en = 1'b0; b_clr = 1'b0;
    endtask

    task automatic drive_b(input bit v, input logic [31:0] d);
        @(negedge clk);
        b_valid = v; b_data = d; b_en = 1'b0; b_clr = 1'b0;
        a_valid = 1'b0; a_data = '0; a_en = 1'b0; a_clr = 1'b0;
    endtask

    task automatic idle_a(input int k);
        for (int i = 0; i < k; i++) drive_a(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    // Hand-computed expectations for instance A (value and, if present, index).
    task automatic expect_a(input string tag, input int v, input int mn, input int mni,
                            input int mx, input int mxi);
        check({tag, "_valid"}, int'(a_ov), v);
        check({tag, "_min"}, int'(a_min), mn);
        check({tag, "_max"}, int'(a_max), mx);
`ifdef MINMAX_INDEX_EN
        check({tag, "_min_idx"}, int'(a_min_idx), mni);
        check({tag, "_max_idx"}, int'(a_max_idx), mxi);
`endif
    endtask

    initial begin
        a_valid = 0; a_data = '0; a_en = 0; a_clr = 0;
        b_valid = 0; b_data = '0; b_en = 0; b_clr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_a("reset", 0, 0, 0, 0, 0);
        check("reset_b_valid", int'(b_ov), 0);

        // Single set {3,1,2,0}: visible three cycles later.
        drive_a(1'b1, pk4(3, 1, 2, 0), 1'b0, 1'b0);
        idle_a(2);
        check("lat_early_valid", int'(a_ov), 0);
        idle_a(1);
        expect_a("single", 1, 0, 3, 3, 0);
        idle_a(1);
        expect_a("hold", 0, 0, 3, 3, 0);

        // Back-to-back sets give consecutive pulses.
        drive_a(1'b1, pk4(1, 1, 1, 1), 1'b0, 1'b0);
        drive_a(1'b1, pk4(2, 3, 3, 0), 1'b0, 1'b0);
        idle_a(2);
        expect_a("b2b_first", 1, 1, 0, 1, 0);
        idle_a(1);
        expect_a("b2b_second", 1, 0, 3, 3, 1);

        // Running mode: ties keep the earliest indices.
        drive_a(1'b1, pk4(2, 2, 2, 2), 1'b1, 1'b0);
        drive_a(1'b1, pk4(1, 3, 2, 2), 1'b1, 1'b0);
        drive_a(1'b1, pk4(2, 2, 2, 2), 1'b1, 1'b0);
        drive_a(1'b0, 8'd0, 1'b1, 1'b0);
        expect_a("acc_1", 1, 2, 0, 2, 0);
        drive_a(1'b0, 8'd0, 1'b1, 1'b0);
        expect_a("acc_2", 1, 1, 1, 3, 1);
        drive_a(1'b0, 8'd0, 1'b1, 1'b0);
        expect_a("acc_3", 1, 1, 1, 3, 1);

        // Clear coincident with a root result: result loads fresh.
        drive_a(1'b1, pk4(0, 0, 0, 0), 1'b1, 1'b0);
        drive_a(1'b0, 8'd0, 1'b1, 1'b0);
        drive_a(1'b0, 8'd0, 1'b1, 1'b1);
        drive_a(1'b0, 8'd0, 1'b0, 1'b0);
        expect_a("acc_clr", 1, 0, 0, 0, 0);

        // Signed 8-lane instance: latency four, ties to lower lane.
        drive_b(1'b1, pk8(-8, 7, 0, -1, 3, -8, 7, 2));
        drive_b(1'b0, '0);
        drive_b(1'b0, '0);
        drive_b(1'b0, '0);
        check("b_lat_early_valid", int'(b_ov), 0);
        drive_b(1'b0, '0);
        check("b_signed_valid", int'(b_ov), 1);
        check("b_signed_min", int'($signed(b_min)), -8);
        check("b_signed_max", int'($signed(b_max)), 7);
`ifdef MINMAX_INDEX_EN
        check("b_signed_min_idx", int'(b_min_idx), 0);
        check("b_signed_max_idx", int'(b_max_idx), 1);
`endif

        // Reset mid-stream discards two in-flight sets.
        drive_a(1'b1, pk4(1, 2, 3, 0), 1'b0, 1'b0);
        drive_a(1'b1, pk4(3, 3, 3, 3), 1'b0, 1'b0);
        drive_a(1'b0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_a("mid_rst", 0, 0, 0, 0, 0);
        check("mid_rst_b_min", int'(b_min), 0);
        a_valid = 1'b1; a_data = pk4(2, 1, 3, 1);
        drive_a(1'b0, 8'd0, 1'b0, 1'b0);
        check("post_rst_quiet1", int'(a_ov), 0);
        drive_a(1'b0, 8'd0, 1'b0, 1'b0);
        check("post_rst_quiet2", int'(a_ov), 0);
        drive_a(1'b0, 8'd0, 1'b0, 1'b0);
        expect_a("post_rst", 1, 1, 1, 3, 2);

        idle_a(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
